// File: rtl/ones_comp_seq_alu.sv
// ones_comp_seq_alu
// Multi-cycle one's-complement ALU for AGC-format words. Add and subtract
// finish in one cycle; multiply (shift-add, LSB first) and divide
// (restoring, MSB first) share one iterative step unit and a pair of
// magnitude registers. Double-word results carry the same sign in both words.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, op         request (sampled only while idle) and operation
//                     00 add, 01 sub (x-y), 10 mult, 11 div
//   x, y, numer_lo    operands; for div x:numer_lo is the dividend, y divisor
//   busy, done        busy from accept through done; done is a 1-cycle pulse
//   result_hi/lo      sum|diff / 0, product hi / lo, quotient / remainder
//   overflow          add/sub sign overflow, or div quotient out of range
//   div_by_zero       div with divisor +0 or -0
module ones_comp_seq_alu #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] numer_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int M  = WIDTH - 1;      // magnitude bits per word
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_reg;
    logic [M-1:0]   hi_reg;             // mult: partial product hi / div: partial remainder
    logic [M-1:0]   lo_reg;             // mult: multiplier then product lo / div: dividend then quotient
    logic [M-1:0]   b_reg;              // mult: multiplicand magnitude / div: divisor magnitude
    logic           is_div_reg;
    logic           sign_q_reg;         // product / quotient sign
    logic           sign_r_reg;         // remainder sign
    logic [CW-1:0]  cnt_reg;

    // Operand decode
    logic           sx, sy;
    logic [M-1:0]   x_mag, y_mag, n_mag;
    assign sx    = x[WIDTH-1];
    assign sy    = y[WIDTH-1];
    assign x_mag = sx ? ~x[M-1:0] : x[M-1:0];
    assign y_mag = sy ? ~y[M-1:0] : y[M-1:0];
    // Low dividend word takes its sign from x; its own sign bit is ignored.
    assign n_mag = sx ? ~numer_lo[M-1:0] : numer_lo[M-1:0];

    // Add / subtract with end-around carry
    logic [WIDTH-1:0] y_eff, add_res;
    logic [WIDTH:0]   add_sum;
    logic             add_ovf;
    assign y_eff   = op[0] ? ~y : y;
    assign add_sum = {1'b0, x} + {1'b0, y_eff};
    assign add_res = add_sum[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
    assign add_ovf = (x[WIDTH-1] == y_eff[WIDTH-1]) && (add_res[WIDTH-1] != x[WIDTH-1]);

    logic div_zero, div_big;
    assign div_zero = (y_mag == '0);
    assign div_big  = (x_mag >= y_mag);

    // Shared iteration step. The first step runs on the accept edge straight
    // from the operands, so CALC only needs M-1 further cycles.
    logic           idle, step_div;
    logic [M-1:0]   step_hi_in, step_lo_in, step_b;
    logic [M-1:0]   step_hi_next, step_lo_next;
    logic [M:0]     mult_sum, div_t, div_diff;
    logic           div_ge;

    assign idle       = (state_reg == IDLE);
    assign step_div   = idle ? op[0] : is_div_reg;
    assign step_hi_in = idle ? (op[0] ? x_mag : '0) : hi_reg;
    assign step_lo_in = idle ? (op[0] ? n_mag : y_mag) : lo_reg;
    assign step_b     = idle ? (op[0] ? y_mag : x_mag) : b_reg;

    assign mult_sum = {1'b0, step_hi_in} + (step_lo_in[0] ? {1'b0, step_b} : '0);
    assign div_t    = {step_hi_in, step_lo_in[M-1]};
    assign div_ge   = (div_t >= {1'b0, step_b});
    assign div_diff = div_t - {1'b0, step_b};

    always_comb begin
        if (step_div) begin
            // Remainder stays below the divisor, so it always fits in M bits.
            step_hi_next = div_ge ? div_diff[M-1:0] : div_t[M-1:0];
            step_lo_next = {step_lo_in[M-2:0], div_ge};
        end else begin
            step_hi_next = mult_sum[M:1];
            step_lo_next = {mult_sum[0], step_lo_in[M-1:1]};
        end
    end

    // Final signed words built from the last step's output
    logic [WIDTH-1:0] fin_hi, fin_lo;
    always_comb begin
        if (is_div_reg) begin
            fin_hi = {sign_q_reg, step_lo_next ^ {M{sign_q_reg}}};
            fin_lo = {sign_r_reg, step_hi_next ^ {M{sign_r_reg}}};
        end else begin
            fin_hi = {sign_q_reg, step_hi_next ^ {M{sign_q_reg}}};
            fin_lo = {sign_q_reg, step_lo_next ^ {M{sign_q_reg}}};
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, numer_lo[WIDTH-1], div_diff[M]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            b_reg       <= '0;
            is_div_reg  <= 1'b0;
            sign_q_reg  <= 1'b0;
            sign_r_reg  <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy        <= 1'b1;
                        is_div_reg  <= op[0];
                        sign_q_reg  <= sx ^ sy;
                        sign_r_reg  <= sx;
                        b_reg       <= step_b;
                        hi_reg      <= step_hi_next;
                        lo_reg      <= step_lo_next;
                        cnt_reg     <= CW'(M - 2);
                        result_lo   <= '0;
                        if (!op[1]) begin
                            result_hi   <= add_res;
                            overflow    <= add_ovf;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                            state_reg   <= DONE;
                        end else if (op[0] && (div_zero || div_big)) begin
                            result_hi   <= '0;
                            overflow    <= 1'b1;
                            div_by_zero <= div_zero;
                            done        <= 1'b1;
                            state_reg   <= DONE;
                        end else begin
                            result_hi   <= '0;
                            overflow    <= 1'b0;
                            div_by_zero <= 1'b0;
                            state_reg   <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi_reg <= step_hi_next;
                    lo_reg <= step_lo_next;
                    if (cnt_reg == '0) begin
                        result_hi <= fin_hi;
                        result_lo <= fin_lo;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ones_comp_seq_alu.sv
// Directed testbench for ones_comp_seq_alu at WIDTH=15.
module tb_ones_comp_seq_alu;
    localparam int W = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] x = '0, y = '0, numer_lo = '0;
    logic         busy, done, overflow, div_by_zero;
    logic [W-1:0] result_hi, result_lo;

    int n_checks = 0;
    int n_pass   = 0;

    ones_comp_seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .x(x), .y(y), .numer_lo(numer_lo),
        .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo),
        .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] x, y, n, rh, rl;
        logic         ov, dz;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    // Issue one op; lat counts edges from the accept edge up to the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] nl, input logic hold_start, output int lat);
        op = o; x = a; y = b; numer_lo = nl; start = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        // Scramble operands to confirm they were latched
        x = ~a; y = ~b; numer_lo = ~nl; op = ~o;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int extra;
        vecs[0]  = '{"add_neg0",  2'b00, 15'h0005, 15'h7FFA, 15'h0000, 15'h7FFF, 15'h0000, 1'b0, 1'b0, 1};
        vecs[1]  = '{"sub_ovf",   2'b01, 15'h3FFF, 15'h7FFE, 15'h0000, 15'h4000, 15'h0000, 1'b1, 1'b0, 1};
        vecs[2]  = '{"add_eac",   2'b00, 15'h7FFE, 15'h0003, 15'h0000, 15'h0002, 15'h0000, 1'b0, 1'b0, 1};
        vecs[3]  = '{"sub_neg0",  2'b01, 15'h0005, 15'h0005, 15'h0000, 15'h7FFF, 15'h0000, 1'b0, 1'b0, 1};
        vecs[4]  = '{"mul_pos",   2'b10, 15'h3FFF, 15'h3FFF, 15'h0000, 15'h3FFE, 15'h0001, 1'b0, 1'b0, 14};
        vecs[5]  = '{"mul_neg",   2'b10, 15'h0003, 15'h7FFD, 15'h0000, 15'h7FFF, 15'h7FF9, 1'b0, 1'b0, 14};
        vecs[6]  = '{"mul_zneg",  2'b10, 15'h0000, 15'h7FFD, 15'h0000, 15'h7FFF, 15'h7FFF, 1'b0, 1'b0, 14};
        vecs[7]  = '{"div_pos",   2'b11, 15'h0001, 15'h2000, 15'h0000, 15'h0002, 15'h0000, 1'b0, 1'b0, 14};
        vecs[8]  = '{"div_negy",  2'b11, 15'h0001, 15'h5FFF, 15'h0000, 15'h7FFD, 15'h0000, 1'b0, 1'b0, 14};
        vecs[9]  = '{"div_negx",  2'b11, 15'h7FFF, 15'h0002, 15'h7FF8, 15'h7FFC, 15'h7FFE, 1'b0, 1'b0, 14};
        vecs[10] = '{"div_z0",    2'b11, 15'h0001, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 1'b1, 1'b1, 1};
        vecs[11] = '{"div_zm0",   2'b11, 15'h0001, 15'h7FFF, 15'h0000, 15'h0000, 15'h0000, 1'b1, 1'b1, 1};

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", result_hi, 0);
        check("rst_lo", result_lo, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].n, 1'b0, lat);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].name, "_busy"}, busy, 1);
            check({vecs[i].name, "_hi"}, result_hi, vecs[i].rh);
            check({vecs[i].name, "_lo"}, result_lo, vecs[i].rl);
            check({vecs[i].name, "_ovf"}, overflow, vecs[i].ov);
            check({vecs[i].name, "_dbz"}, div_by_zero, vecs[i].dz);
            $display("op %s x=%h y=%h n=%h -> hi=%h lo=%h ovf=%0d dbz=%0d lat=%0d",
                     vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].n,
                     result_hi, result_lo, overflow, div_by_zero, lat);
            @(posedge clk); #1;
            check({vecs[i].name, "_done_pulse"}, done, 0);
            check({vecs[i].name, "_idle"}, busy, 0);
            check({vecs[i].name, "_hold"}, result_hi, vecs[i].rh);
        end

        // Quotient out of range
        run_op(2'b11, 15'h2000, 15'h1000, 15'h0000, 1'b0, lat);
        check("div_big_lat", lat, 1);
        check("div_big_ovf", overflow, 1);
        check("div_big_dbz", div_by_zero, 0);
        check("div_big_hi", result_hi, 0);
        $display("op div_big -> ovf=%0d dbz=%0d", overflow, div_by_zero);
        @(posedge clk); #1;

        // Results clear on the accept edge of the next operation
        op = 2'b10; x = 15'h0002; y = 15'h0003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("accept_clr_ovf", overflow, 0);
        check("accept_clr_hi", result_hi, 0);
        extra = 0;
        while (!done && extra < 40) begin @(posedge clk); #1; extra++; end
        check("mul6_lo", result_lo, 15'h0006);
        $display("op mul6 -> hi=%h lo=%h", result_hi, result_lo);
        @(posedge clk); #1;

        // start held high through a whole multiply: exactly one done
        run_op(2'b10, 15'h0007, 15'h0005, 15'h0000, 1'b1, lat);
        check("hold_lat", lat, 14);
        check("hold_lo", result_lo, 15'h0023);
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("hold_extra_done", extra, 0);
        $display("op hold_start -> lo=%h extra_done=%0d", result_lo, extra);

        // Reset in the middle of a multiply
        op = 2'b10; x = 15'h3FFF; y = 15'h3FFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk); rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("midrst_no_done", extra, 0);
        $display("op midreset -> done_after_release=%0d", extra);
        run_op(2'b10, 15'h3FFF, 15'h3FFF, 15'h0000, 1'b0, lat);
        check("post_rst_lat", lat, 14);
        check("post_rst_hi", result_hi, 15'h3FFE);
        check("post_rst_lo", result_lo, 15'h0001);
        $display("op post_reset_mul -> hi=%h lo=%h lat=%0d", result_hi, result_lo, lat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
